reorder_in: RTL and testbench
=============================

REORDER_IN -- requirements
Module: reorder_in

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4, meaning log2 of transform size N (N = 2**NUM_STAGES, pairs P = N/2).
REQ-002 SHALL have parameter DATA_W, default 16, meaning coefficient width in bits.
REQ-003 SHALL have port clk, input, 1, clock.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, upstream coefficient valid.
REQ-006 SHALL have port in_ready, output, 1, block accepts a coefficient this cycle.
REQ-007 SHALL have port in_data, input, DATA_W, coefficient in natural order (index 0 first).
REQ-008 SHALL have port out_valid, output, 1, butterfly pair presented.
REQ-009 SHALL have port out_ready, input, 1, first NTT stage consumes pair.
REQ-010 SHALL have ports out_top and out_bot, output, DATA_W each, pair operands.
REQ-011 SHALL have port out_last, output, 1, high with the final pair (k = P-1) of a frame.

Function
REQ-012 SHALL hold an internal N-entry x DATA_W register buffer; single buffer, no ping-pong.
REQ-013 SHALL implement two states: LOAD and EMIT.
REQ-014 LOAD: in_ready=1, out_valid=0; on in_valid&&in_ready write buf[wr_cnt] <= in_data, wr_cnt increments.
REQ-015 LOAD -> EMIT on the accepted transfer with wr_cnt == N-1; wr_cnt wraps to 0.
REQ-016 EMIT: in_ready=0, out_valid=1; pair counter k presents out_top = buf[bitrev(2k)], out_bot = buf[bitrev(2k+1)] (equivalently buf[j], buf[j+N/2], j = bitrev(2k)).
REQ-017 bitrev SHALL reverse all NUM_STAGES address bits.
REQ-018 Outputs SHALL be driven from buf and k with zero added latency; first pair visible the cycle after the last input handshake.
REQ-019 k SHALL advance only on out_valid&&out_ready; out_top/out_bot/out_last stable while out_ready=0.
REQ-020 out_last = (state==EMIT) && (k == P-1).
REQ-021 EMIT -> LOAD on handshake with k == P-1; k wraps to 0; in_ready=1 the following cycle.
REQ-022 in_valid in EMIT SHALL be ignored (no write, buffer unchanged).
REQ-023 in_data SHALL never be written to buf unless in_ready=1.
REQ-024 Back-to-back frames SHALL need no idle cycles beyond the state change.
REQ-025 Buffer contents are undefined until written; no requirement to clear on reset.

Reset
REQ-026 On reset: state=LOAD, wr_cnt=0, k=0; in_ready=1, out_valid=0, out_last=0 in the cycle after reset deasserts.
REQ-027 Reset mid-LOAD or mid-EMIT SHALL abandon the partial frame; next accepted word is index 0.
REQ-028 reset SHALL dominate in_valid/out_ready in the same cycle.

Structure
REQ-029 Shared package ntt_pkg SHALL hold NUM_STAGES default, DATA_W default, state enum (LOAD, EMIT), and N/P localparam derivations.
REQ-030 One sub-module ntt_bitrev (combinational, parameter NUM_STAGES) SHALL compute bit-reversed addresses; instantiated twice (top and bottom addresses).

Verification
REQ-031 Frame: N=16, inputs 0..15, out_ready=1 -> pairs (0,8),(4,12),(2,10),(6,14),(1,9),(5,13),(3,11),(7,15); out_last only on (7,15).
REQ-032 Backpressure: out_ready toggled 1,0,0,1 during EMIT -> each pair held stable while stalled, no pair skipped or duplicated, 8 handshakes total.
REQ-033 Gapped input: in_valid pattern 1,0,1,1,0... over 16 accepts -> same output as REQ-031; in_valid in EMIT with data 0xFFFF -> no corruption.
REQ-034 Back-to-back: frame A 0..15 then frame B 100..115 -> second frame yields (100,108),(104,112),...,(107,115); in_ready rises cycle after (7,15) handshake.
REQ-035 Reset mid-frame: reset after 5 inputs and after 3 output pairs -> in_ready=1, out_valid=0; subsequent 0..15 frame matches REQ-031.
REQ-036 Parameter sweep: NUM_STAGES=3 inputs 0..7 -> (0,4),(2,6),(1,5),(3,7).

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT front end: default sizes, the frame
// size derivations and the reorder buffer state encoding.
package ntt_pkg;

  localparam int NTT_NUM_STAGES = 4;
  localparam int NTT_DATA_W     = 16;
  localparam int NTT_N          = 1 << NTT_NUM_STAGES;
  localparam int NTT_P          = NTT_N / 2;

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Transform size for a given number of butterfly stages.
  function automatic int ntt_size(input int stages);
    return 1 << stages;
  endfunction

endpackage

// File: rtl/ntt_bitrev.sv
// Combinational bit reversal of a NUM_STAGES-bit buffer address.
module ntt_bitrev #(
  parameter int NUM_STAGES = 4
) (
  input  logic [NUM_STAGES-1:0] addr,
  output logic [NUM_STAGES-1:0] rev
);

  // Mirror every address bit: bit b moves to bit NUM_STAGES-1-b.
  always_comb begin
    rev = '0;
    for (int b = 0; b < NUM_STAGES; b++) begin
      rev[NUM_STAGES-1-b] = addr[b];
    end
  end

endmodule

// File: rtl/reorder_in.sv
// Input reorder buffer for the first NTT stage. Collects N coefficients
// in natural order, then presents them as butterfly pairs in bit-reversed
// order (top = buf[bitrev(2k)], bottom = buf[bitrev(2k+1)]).
//
// Handshakes: a transfer happens on a rising clk edge where valid and
// ready are both high. in_ready is high exactly in LOAD and out_valid
// exactly in EMIT; neither depends combinationally on the opposite side's
// valid/ready, and the presented pair holds steady until it is taken.
module reorder_in
  import ntt_pkg::*;
#(
  parameter int NUM_STAGES = NTT_NUM_STAGES,
  parameter int DATA_W     = NTT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_top,
  output logic [DATA_W-1:0] out_bot,
  output logic              out_last,
  output state_e            fsm_state
);

  localparam int N = ntt_size(NUM_STAGES);
  localparam int P = N / 2;
  localparam logic [NUM_STAGES-1:0] WR_LAST = NUM_STAGES'(N - 1);
  localparam logic [NUM_STAGES-2:0] K_LAST  = (NUM_STAGES-1)'(P - 1);

  state_e                  state;
  logic [NUM_STAGES-1:0]   wr_cnt;
  logic [NUM_STAGES-2:0]   k;
  logic [DATA_W-1:0]       mem [N];
  logic [NUM_STAGES-1:0]   top_addr;
  logic [NUM_STAGES-1:0]   bot_addr;
  logic                    in_fire;
  logic                    out_fire;

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == EMIT);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign fsm_state = state;

  // Pair k uses the even/odd natural indices 2k and 2k+1, reversed.
  ntt_bitrev #(.NUM_STAGES(NUM_STAGES)) u_rev_top (
    .addr ({k, 1'b0}),
    .rev  (top_addr)
  );

  ntt_bitrev #(.NUM_STAGES(NUM_STAGES)) u_rev_bot (
    .addr ({k, 1'b1}),
    .rev  (bot_addr)
  );

  assign out_top  = mem[top_addr];
  assign out_bot  = mem[bot_addr];
  assign out_last = (state == EMIT) && (k == K_LAST);

  // Frame sequencing: fill N words, then hand out P pairs, then refill.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= LOAD;
      wr_cnt <= '0;
      k      <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_fire) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_cnt == WR_LAST) begin
              state <= EMIT;
            end
          end
        end
        EMIT: begin
          if (out_fire) begin
            k <= k + 1'b1;
            if (k == K_LAST) begin
              state <= LOAD;
            end
          end
        end
        default: begin
          state  <= LOAD;
          wr_cnt <= '0;
          k      <= '0;
        end
      endcase
    end
  end

  // Coefficient storage; written only on an accepted input word.
  always_ff @(posedge clk) begin
    if (!reset && in_fire) begin
      mem[wr_cnt] <= in_data;
    end
  end

endmodule

// File: tb/tb_reorder_in.sv
// Bench for reorder_in: randomized and directed frames, a scoreboard queue
// fed by the stimulus side and drained by an output monitor, plus a
// NUM_STAGES=3 instance for the small-size case.
module tb_reorder_in;
  import ntt_pkg::*;

  localparam int NS  = 4;
  localparam int DW  = 16;
  localparam int N   = 1 << NS;
  localparam int P   = N / 2;
  localparam int NS3 = 3;
  localparam int N3  = 1 << NS3;
  localparam int P3  = N3 / 2;
  localparam int EW  = 2 * DW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, out_valid, out_ready, out_last;
  logic [DW-1:0] in_data, out_top, out_bot;
  state_e        fsm_state;

  logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last;
  logic [DW-1:0] s_in_data, s_out_top, s_out_bot;
  state_e        s_fsm_state;

  reorder_in #(.NUM_STAGES(NS), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_top(out_top), .out_bot(out_bot), .out_last(out_last),
    .fsm_state(fsm_state)
  );

  reorder_in #(.NUM_STAGES(NS3), .DATA_W(DW)) dut3 (
    .clk(clk), .reset(reset),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_top(s_out_top), .out_bot(s_out_bot), .out_last(s_out_last),
    .fsm_state(s_fsm_state)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;
  int rdy_mode = 0;
  logic [3:0] bp_pat = 4'b1001;   // out_ready sequence 1,0,0,1
  logic [4:0] gap_pat = 5'b01101; // in_valid sequence 1,0,1,1,0

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned rev_bits(input int unsigned v, input int bits);
    int unsigned r = 0;
    for (int b = 0; b < bits; b++) begin
      if (((v >> b) & 1) != 0) r = r | (1 << (bits - 1 - b));
    end
    return r;
  endfunction

  // Pair k of a frame: top is vals[j], bottom vals[j + N/2], j = rev(2k).
  function automatic logic [EW-1:0] model_pair(input int unsigned vals[16], input int stages, input int k);
    int n = 1 << stages;
    int unsigned j = rev_bits(2 * k, stages);
    logic last = (k == n / 2 - 1);
    logic [DW-1:0] t = DW'(vals[j]);
    logic [DW-1:0] b = DW'(vals[j + n / 2]);
    return {last, t, b};
  endfunction

  // ---------------- out_ready driver ----------------
  initial begin
    int bp_i = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = bp_pat[bp_i % 4]; bp_i++; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- output monitor ----------------
  initial begin
    logic          held_v = 1'b0;
    logic [EW-1:0] held = '0;
    logic          last_pending = 1'b0;
    logic [EW-1:0] cur;
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        held_v = 1'b0;
        last_pending = 1'b0;
      end else begin
        cur = {out_last, out_top, out_bot};
        if (last_pending) begin
          check("in_ready_after_last", 64'(in_ready), 64'd1);
          last_pending = 1'b0;
        end
        if (held_v && out_valid) check("stall_stable", 64'(cur), 64'(held));
        if (out_valid && out_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_pair", 64'(cur), 64'h0);
            errors += (cur == '0) ? 1 : 0;
          end else begin
            e = exp_q.pop_front();
            check("pair", 64'(cur), 64'(e));
          end
          if (out_last) last_pending = 1'b1;
        end
        held_v = out_valid && !out_ready;
        held   = cur;
      end
    end
  end

  // ---------------- input driver tasks ----------------
  // Sends nwords of a frame (data base+i or random). When the frame is
  // complete its expected pairs are queued; with wait_done the task keeps
  // in_valid high with junk through EMIT and checks the frame drained.
  task automatic send_frame(input int base, input bit rnd, input bit gap,
                            input int nwords, input bit wait_done);
    int unsigned vals[16];
    int i = 0;
    int c = 0;
    int guard = 0;
    int hs0 = hs_cnt;
    bit acc;
    for (int w = 0; w < N; w++) vals[w] = rnd ? $urandom_range(0, 16'hFFFE) : (base + w);
    if (nwords == N) begin
      for (int kk = 0; kk < P; kk++) exp_q.push_back(model_pair(vals, NS, kk));
    end
    while (i < nwords && guard < 1000) begin
      if (gap && !gap_pat[c % 5]) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = DW'(vals[i]);
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      c++;
      guard++;
    end
    in_valid = 1'b0;
    if (i < nwords) check("load_timeout", 64'(i), 64'(nwords));
    if (wait_done && nwords == N) begin
      guard = 0;
      while (out_valid && guard < 1000) begin
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        @(posedge clk); #1;
        guard++;
      end
      in_valid = 1'b0;
      if (guard >= 1000) check("emit_timeout", 64'(guard), 64'd0);
      check("frame_handshakes", 64'(hs_cnt - hs0), 64'(P));
      check("frame_drained", 64'(exp_q.size()), 64'd0);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_state", 64'(fsm_state), 64'(LOAD));
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int hs0;
    int guard;
    int unsigned v3[16];
    int k3;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    s_in_valid = 1'b0;
    s_in_data = '0;
    s_out_ready = 1'b1;

    do_reset();
    check("rst3_in_ready", 64'(s_in_ready), 64'd1);
    check("rst3_out_valid", 64'(s_out_valid), 64'd0);

    // natural frame, free-flowing output
    send_frame(0, 1'b0, 1'b0, N, 1'b1);
    // backpressure 1,0,0,1
    rdy_mode = 1;
    send_frame(0, 1'b0, 1'b0, N, 1'b1);
    rdy_mode = 0;
    // gapped input with junk during EMIT
    send_frame(0, 1'b0, 1'b1, N, 1'b1);
    // back-to-back frames
    send_frame(0, 1'b0, 1'b0, N, 1'b1);
    send_frame(100, 1'b0, 1'b0, N, 1'b1);

    // reset after 5 inputs
    send_frame(0, 1'b0, 1'b0, 5, 1'b0);
    do_reset();
    send_frame(0, 1'b0, 1'b0, N, 1'b1);

    // reset after 3 output pairs
    hs0 = hs_cnt;
    send_frame(200, 1'b0, 1'b0, N, 1'b0);
    guard = 0;
    while (hs_cnt < hs0 + 3 && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    check("mid_emit_pairs", 64'(hs_cnt - hs0), 64'd3);
    do_reset();
    send_frame(0, 1'b0, 1'b0, N, 1'b1);

    // randomized data, gaps and backpressure
    rdy_mode = 2;
    for (int f = 0; f < 6; f++) send_frame(0, 1'b1, f[0], N, 1'b1);
    rdy_mode = 0;

    // NUM_STAGES=3 instance, inputs 0..7
    for (int w = 0; w < 16; w++) v3[w] = w;
    for (int w = 0; w < N3; w++) begin
      s_in_valid = 1'b1;
      s_in_data  = DW'(w);
      @(negedge clk);
      check("s_in_ready", 64'(s_in_ready), 64'd1);
      @(posedge clk); #1;
    end
    s_in_valid = 1'b0;
    k3 = 0;
    guard = 0;
    while (k3 < P3 && guard < 50) begin
      @(negedge clk);
      if (s_out_valid && s_out_ready) begin
        check("s_pair", 64'({s_out_last, s_out_top, s_out_bot}), 64'(model_pair(v3, NS3, k3)));
        k3++;
      end
      @(posedge clk); #1;
      guard++;
    end
    check("s_pair_count", 64'(k3), 64'(P3));
    @(negedge clk);
    check("s_back_to_load", 64'(s_in_ready), 64'd1);

    repeat (3) @(posedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
